uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_arb_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 95 +++++++++
 rtl/uart_tx_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and default sizing for the uart_tx_arbiter codebase slice.
package uart_arb_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_DATA_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin winner selection with its rotation pointer.
// With UART_ARB_PRIORITY_EN defined, requester 0 has absolute priority and 1..N-1 rotate.
module rr_arbiter
    import uart_arb_pkg::*;
#(
    parameter int  NUM_REQ = DEF_NUM_REQ,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_advance,
    output logic [NUM_REQ-1:0] o_winner,
    output logic [IDX_W-1:0]   o_winner_idx,
    output logic               o_valid
);

    localparam logic [IDX_W:0]     NUM_REQ_W   = (IDX_W+1)'(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE_HOT_LSB = NUM_REQ'(1);

    logic [IDX_W-1:0]   r_start;
    logic [NUM_REQ-1:0] w_req_rr;
    logic [IDX_W-1:0]   w_cand [NUM_REQ];
    logic [IDX_W-1:0]   w_rr_idx;
    logic               w_rr_found;
    logic [IDX_W-1:0]   w_idx;
    logic               w_valid;
    logic [IDX_W:0]     w_inc;
    logic [IDX_W-1:0]   w_next_start;

    // Candidate k is (start + k) mod NUM_REQ, computed without a divider.
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_cand
        logic [IDX_W:0] w_sum;
        assign w_sum     = {1'b0, r_start} + (IDX_W+1)'(k);
        assign w_cand[k] = (w_sum >= NUM_REQ_W) ? IDX_W'(w_sum - NUM_REQ_W) : w_sum[IDX_W-1:0];
    end

`ifdef UART_ARB_PRIORITY_EN
    assign w_req_rr = i_req & ~ONE_HOT_LSB;
`else
    assign w_req_rr = i_req;
`endif

    // First requesting candidate in rotation order.
    always_comb begin
        w_rr_idx   = '0;
        w_rr_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_rr_found && w_req_rr[w_cand[k]]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = w_cand[k];
            end else begin
                w_rr_found = w_rr_found;
            end
        end
    end

    // Final winner, applying the optional fixed priority of requester 0.
    always_comb begin
        w_idx   = w_rr_idx;
        w_valid = w_rr_found;
`ifdef UART_ARB_PRIORITY_EN
        if (i_req[0]) begin
            w_idx   = '0;
            w_valid = 1'b1;
        end else begin
            w_idx   = w_rr_idx;
            w_valid = w_rr_found;
        end
`endif
    end

    assign w_inc        = {1'b0, w_idx} + (IDX_W+1)'(1);
    assign w_next_start = (w_inc >= NUM_REQ_W) ? '0 : w_inc[IDX_W-1:0];

    // Rotation pointer: the search resumes just after the last rotating winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_start <= '0;
`ifdef UART_ARB_PRIORITY_EN
        end else if (i_advance && w_valid && (w_idx != '0)) begin
`else
        end else if (i_advance && w_valid) begin
`endif
            r_start <= w_next_start;
        end else begin
            r_start <= r_start;
        end
    end

    assign o_winner     = w_valid ? (ONE_HOT_LSB << w_idx) : '0;
    assign o_winner_idx = w_idx;
    assign o_valid      = w_valid;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between NUM_REQ requesters, one frame at a time.
// Optional feature: UART_ARB_PRIORITY_EN gives requester 0 absolute priority.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_parity_en,
    input  logic [NUM_REQ-1:0]          req_even_parity,
    output logic [NUM_REQ-1:0]          grant,
    output logic [NUM_REQ-1:0]          done,
    output logic                        tx_start,
    output logic [DATA_W-1:0]           data_in,
    output logic                        parity_en,
    output logic                        even_parity,
    input  logic                        tx_busy,
    output logic [$clog2(NUM_REQ)-1:0]  owner,
    output logic                        arb_busy
);

    localparam int                 IDX_W       = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE_HOT_LSB = NUM_REQ'(1);

    arb_state_t         r_state;
    arb_state_t         w_next;
    logic               w_advance;
    logic               w_finish;
    logic [NUM_REQ-1:0] w_winner;
    logic [IDX_W-1:0]   w_win_idx;
    logic               w_win_valid;
    logic [DATA_W-1:0]  w_bytes [NUM_REQ];

    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] r_done;
    logic               r_tx_start;
    logic [DATA_W-1:0]  r_data_in;
    logic               r_parity_en;
    logic               r_even_parity;
    logic [IDX_W-1:0]   r_owner;
    logic               r_arb_busy;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_bytes
        assign w_bytes[i] = req_data[i*DATA_W +: DATA_W];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .clk          (clk),
        .rst          (rst),
        .i_req        (req),
        .i_advance    (w_advance),
        .o_winner     (w_winner),
        .o_winner_idx (w_win_idx),
        .o_valid      (w_win_valid)
    );

    // Frame state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state plus the accept/finish strobes; only IDLE looks at requests.
    always_comb begin
        w_next    = r_state;
        w_advance = 1'b0;
        w_finish  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_win_valid && !tx_busy) begin
                    w_next    = ST_ISSUE;
                    w_advance = 1'b1;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                w_next = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    w_next = ST_WAIT_DONE;
                end else begin
                    w_next = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    w_next   = ST_IDLE;
                    w_finish = 1'b1;
                end else begin
                    w_next = ST_WAIT_DONE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Registered outputs; tx_start is the registered image of the ISSUE cycle,
    // so it trails grant by exactly one clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant       <= '0;
            r_done        <= '0;
            r_tx_start    <= 1'b0;
            r_data_in     <= '0;
            r_parity_en   <= 1'b0;
            r_even_parity <= 1'b0;
            r_owner       <= '0;
            r_arb_busy    <= 1'b0;
        end else begin
            r_grant    <= w_advance ? w_winner : '0;
            r_done     <= w_finish ? (ONE_HOT_LSB << r_owner) : '0;
            r_tx_start <= (r_state == ST_ISSUE);
            r_arb_busy <= (w_next != ST_IDLE);
            if (w_advance) begin
                r_data_in     <= w_bytes[w_win_idx];
                r_parity_en   <= req_parity_en[w_win_idx];
                r_even_parity <= req_even_parity[w_win_idx];
                r_owner       <= w_win_idx;
            end else begin
                r_data_in     <= r_data_in;
                r_parity_en   <= r_parity_en;
                r_even_parity <= r_even_parity;
                r_owner       <= r_owner;
            end
        end
    end

    assign grant       = r_grant;
    assign done        = r_done;
    assign tx_start    = r_tx_start;
    assign data_in     = r_data_in;
    assign parity_en   = r_parity_en;
    assign even_parity = r_even_parity;
    assign owner       = r_owner;
    assign arb_busy    = r_arb_busy;

endmodule
